// File: rtl/eight_bit_shift_add_multiplier_pkg.sv
// Shared constants and state encoding for the shift-add multiplier.
package eight_bit_shift_add_multiplier_pkg;

  localparam int unsigned OPW       = 8;
  localparam int unsigned MUL_ITERS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/eight_bit_shift_add_multiplier_adder.sv
// Existing 8-bit ripple adder; the multiplier's only arithmetic element.
module eight_bit_adder (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       carry_in,
  output logic [7:0] sum,
  output logic       carry_out
);

  assign {carry_out, sum} = {1'b0, x} + {1'b0, y} + {8'b0, carry_in};

endmodule

// File: rtl/eight_bit_shift_add_multiplier.sv
// Iterative 8x8 unsigned multiplier: one add-and-shift per cycle through eight_bit_adder.
import eight_bit_shift_add_multiplier_pkg::*;

module eight_bit_shift_add_multiplier (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [OPW-1:0]       x,
  input  logic [OPW-1:0]       y,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*OPW-1:0]     product
);

  localparam logic [3:0] LAST_ITER = 4'(MUL_ITERS - 1);

  state_e             state_q, state_d;
  logic [OPW-1:0]     m_q, m_d;
  logic [OPW-1:0]     a_q, a_d;
  logic [OPW-1:0]     q_q, q_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [2*OPW-1:0]   product_q, product_d;

  logic [OPW-1:0]     add_y;
  logic [OPW-1:0]     add_sum;
  logic               add_co;

  assign add_y = q_q[0] ? m_q : '0;

  eight_bit_adder u_adder (
    .x         (a_q),
    .y         (add_y),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_co)
  );

  // The carry is folded straight into A's MSB on each shift, so the C
  // register would always reload to 0 and is not kept as separate state.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        ready = 1'b1;
        done  = (state_q == DONE);
        if (start) begin
          m_d     = x;
          q_d     = y;
          a_d     = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        busy  = 1'b1;
        a_d   = {add_co, add_sum[OPW-1:1]};
        q_d   = {add_sum[0], q_q[OPW-1:1]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_ITER) begin
          product_d = {add_co, add_sum, q_q[OPW-1:1]};
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_eight_bit_shift_add_multiplier.sv
// Self-checking bench for eight_bit_shift_add_multiplier: vector table, corner sequences, random sweep.
module tb_eight_bit_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  x, y;
  logic        ready, busy, done;
  logic [15:0] product;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] last_prod;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  eight_bit_shift_add_multiplier dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .x       (x),
    .y       (y),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait for done starting one negedge after the accepting edge; returns negedges counted.
  task automatic wait_done(input bit hold, input bit chk_busy, output int n);
    n = 1;
    while (done !== 1'b1 && n <= 12) begin
      if (chk_busy && n <= 8) begin
        check("busy_during_op", {31'b0, busy}, 32'd1);
        if (n == 4) check("product_held", {16'b0, product}, {16'b0, last_prod});
      end
      if (hold) begin
        x = 8'($urandom);
        y = 8'($urandom);
      end
      if (n == 8) start = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit hold, input string tag);
    int n;
    logic [15:0] exp;
    exp = 16'(a) * 16'(b);
    @(negedge clk);
    start = 1'b1; x = a; y = b;
    @(negedge clk);
    if (!hold) start = 1'b0;
    wait_done(hold, 1'b1, n);
    check({tag, "_latency"}, n, 32'd9);
    check({tag, "_product"}, {16'b0, product}, {16'b0, exp});
    check({tag, "_ready_in_done"}, {31'b0, ready}, 32'd1);
    last_prod = exp;
    @(negedge clk);
    check({tag, "_done_width"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int seen;
    vecs[0] = '{8'd13,  8'd11,  16'h008F};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd0,   8'd200, 16'h0000};
    vecs[3] = '{8'd200, 8'd0,   16'h0000};
    vecs[4] = '{8'd1,   8'd1,   16'h0001};
    vecs[5] = '{8'd7,   8'd9,   16'h003F};
    vecs[6] = '{8'd128, 8'd2,   16'h0100};
    vecs[7] = '{8'd15,  8'd17,  16'h00FF};

    // Reset, with start asserted throughout
    rst_n = 1'b0; start = 1'b1; x = 8'd55; y = 8'd66;
    last_prod = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_ready",   {31'b0, ready}, 32'd1);
    check("rst_busy",    {31'b0, busy},  32'd0);
    check("rst_done",    {31'b0, done},  32'd0);
    check("rst_product", {16'b0, product}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {31'b0, busy}, 32'd0);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, 1'b0, "table");

    // start held with changing operands through BUSY must be ignored
    run_op(8'd13, 8'd11, 1'b1, "ignore_start");

    // Back-to-back accept from DONE
    @(negedge clk);
    start = 1'b1; x = 8'd1; y = 8'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, 1'b0, n);
    check("b2b_first_latency", n, 32'd9);
    check("b2b_first_product", {16'b0, product}, 32'd1);
    start = 1'b1; x = 8'd2; y = 8'd3;
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_double_done", {31'b0, done}, 32'd0);
    check("b2b_no_idle_gap", {31'b0, busy}, 32'd1);
    @(negedge clk);
    n = 2;
    while (done !== 1'b1 && n <= 12) begin
      @(negedge clk);
      n++;
    end
    check("b2b_second_spacing", n, 32'd9);
    check("b2b_second_product", {16'b0, product}, 32'd6);
    @(negedge clk);
    check("b2b_done_width", {31'b0, done}, 32'd0);
    last_prod = 16'd6;

    // Reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; x = 8'd100; y = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready",   {31'b0, ready}, 32'd1);
    check("abort_busy",    {31'b0, busy},  32'd0);
    check("abort_done",    {31'b0, done},  32'd0);
    check("abort_product", {16'b0, product}, 32'd0);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("abort_stays_idle", seen, 32'd0);
    last_prod = 16'h0000;
    run_op(8'd7, 8'd9, 1'b0, "after_abort");
    check("after_abort_value", {16'b0, product}, 32'h003F);

    // Random sweep against x*y
    for (int i = 0; i < 1000; i++)
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
